// File: rtl/inst_encoder_if.sv
// -----------------------------------------------------------------------------
// inst_encoder_pkg / inst_encoder_if
//
// Purpose:
//   Shared type definitions and the request/response bundle for the RV32I
//   instruction encoder used on the debug/program-loader path.
//
// Package inst_encoder_pkg:
//   encoding_type : selects the RV32I field layout (I/S/B/U). Any other value
//                   passes the immediate through unchanged as a raw word.
//
// Interface inst_encoder_if (modports master = requester, slave = encoder):
//   in_valid     master->slave  request valid
//   in_ready     slave->master  encoder can accept a request this cycle
//   encoding     master->slave  field layout select
//   opcode       master->slave  instruction[6:0]
//   funct3       master->slave  instruction[14:12] (unused for U)
//   rd           master->slave  destination register (I/U)
//   rs1          master->slave  source register 1 (I/S/B)
//   rs2          master->slave  source register 2 (S/B)
//   imm          master->slave  32-bit two's complement immediate
//   out_valid    slave->master  encoded word valid
//   out_ready    master->slave  downstream accepts the word
//   instruction  slave->master  encoded instruction word
//   range_error  slave->master  imm not representable in the selected layout
// -----------------------------------------------------------------------------
package inst_encoder_pkg;

  typedef enum logic [2:0] {
    I_TYPE   = 3'd0,
    S_TYPE   = 3'd1,
    B_TYPE   = 3'd2,
    U_TYPE   = 3'd3,
    RAW_TYPE = 3'd4,
    RSVD5    = 3'd5,
    RSVD6    = 3'd6,
    RSVD7    = 3'd7
  } encoding_type;

endpackage

interface inst_encoder_if;
  import inst_encoder_pkg::*;

  logic         in_valid;
  logic         in_ready;
  encoding_type encoding;
  logic [6:0]   opcode;
  logic [2:0]   funct3;
  logic [4:0]   rd;
  logic [4:0]   rs1;
  logic [4:0]   rs2;
  logic [31:0]  imm;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  instruction;
  logic         range_error;

  modport master (
    output in_valid, encoding, opcode, funct3, rd, rs1, rs2, imm, out_ready,
    input  in_ready, out_valid, instruction, range_error
  );

  modport slave (
    input  in_valid, encoding, opcode, funct3, rd, rs1, rs2, imm, out_ready,
    output in_ready, out_valid, instruction, range_error
  );

endinterface

// File: rtl/inst_encoder.sv
// -----------------------------------------------------------------------------
// inst_encoder
//
// Purpose:
//   Packs an immediate plus register/opcode fields into a 32-bit RV32I
//   instruction word (I, S, B, U layouts; other encodings pass imm through).
//   Two registered stages with valid/ready flow control:
//     stage 1 : captures the request, range-checks the immediate and places
//               the immediate bits at their final instruction positions.
//     stage 2 : merges register/opcode fields and presents the word.
//   enc_count counts output handshakes and wraps at 2**COUNT_W.
//
// Ports:
//   clk        system clock, all state on the rising edge
//   reset_n    synchronous active-low reset
//   bus        inst_encoder_if.slave (request in, encoded word out)
//   enc_count  number of output handshakes since reset
//
// Parameters:
//   COUNT_W    width of enc_count
//
// Build option:
//   INST_ENCODER_DROP_ERR_EN - when defined, requests whose immediate fails the
//   range check are consumed but never presented; instead range_error pulses
//   for one cycle in the slot where the word would have left stage 2, and
//   enc_count does not advance for them.
// -----------------------------------------------------------------------------
module inst_encoder
  import inst_encoder_pkg::*;
#(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  inst_encoder_if.slave      bus,
  output logic [COUNT_W-1:0] enc_count
);

  // ---------------------------------------------------------------------------
  // Immediate helpers
  // ---------------------------------------------------------------------------

  // True when imm fits the signed range of the selected layout.
  function automatic logic imm_in_range(encoding_type enc, logic [31:0] imm);
    logic ok;
    ok = 1'b1;
    case (enc)
      I_TYPE, S_TYPE: ok = (&imm[31:11]) | ~(|imm[31:11]);
      // Branch offsets are 13-bit signed and always even.
      B_TYPE:         ok = ((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0];
      // U immediates arrive pre-shifted; the low 12 bits cannot be encoded.
      U_TYPE:         ok = ~(|imm[11:0]);
      default:        ok = 1'b1;
    endcase
    return ok;
  endfunction

  // Immediate bits scattered to their final positions; all other bits zero so
  // stage 2 can simply OR in the register and opcode fields.
  function automatic logic [31:0] imm_place(encoding_type enc, logic [31:0] imm);
    logic [31:0] bits;
    bits = 32'h0;
    case (enc)
      I_TYPE:  bits = {imm[11:0], 20'h0};
      S_TYPE:  bits = {imm[11:5], 13'h0, imm[4:0], 7'h0};
      B_TYPE:  bits = {imm[12], imm[10:5], 13'h0, imm[4:1], imm[11], 7'h0};
      U_TYPE:  bits = {imm[31:12], 12'h0};
      default: bits = imm;
    endcase
    return bits;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------

  // Stage 1
  logic         s1_valid_q,    s1_valid_d;
  encoding_type s1_enc_q,      s1_enc_d;
  logic [6:0]   s1_opcode_q,   s1_opcode_d;
  logic [2:0]   s1_funct3_q,   s1_funct3_d;
  logic [4:0]   s1_rd_q,       s1_rd_d;
  logic [4:0]   s1_rs1_q,      s1_rs1_d;
  logic [4:0]   s1_rs2_q,      s1_rs2_d;
  logic [31:0]  s1_imm_bits_q, s1_imm_bits_d;
  logic         s1_err_q,      s1_err_d;

  // Stage 2
  logic         s2_valid_q,    s2_valid_d;
  logic [31:0]  s2_instr_q,    s2_instr_d;
  logic         s2_err_q,      s2_err_d;
  // Marks a slot occupied by a dropped (range-failing) request; only ever set
  // when the drop option is built in.
  logic         s2_drop_q,     s2_drop_d;

  logic [COUNT_W-1:0] count_q, count_d;

  // Flow control
  logic        s2_advance;
  logic        in_fire;
  logic        out_fire;
  logic [31:0] s1_word;

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------

  // A dropped slot never holds out_valid, so stage 2 always moves past it
  // the next cycle, which is what bounds the range_error pulse to one cycle.
  assign s2_advance   = ~s2_valid_q | bus.out_ready;
  assign bus.in_ready = ~s1_valid_q | s2_advance;
  assign in_fire      = bus.in_valid & bus.in_ready;
  assign out_fire     = s2_valid_q & bus.out_ready;

  // ---------------------------------------------------------------------------
  // Stage 1 next-state
  // ---------------------------------------------------------------------------
  // NOTE: every signal written in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    s1_valid_d    = s1_valid_q;
    s1_enc_d      = s1_enc_q;
    s1_opcode_d   = s1_opcode_q;
    s1_funct3_d   = s1_funct3_q;
    s1_rd_d       = s1_rd_q;
    s1_rs1_d      = s1_rs1_q;
    s1_rs2_d      = s1_rs2_q;
    s1_imm_bits_d = s1_imm_bits_q;
    s1_err_d      = s1_err_q;

    // in_ready already implies stage 1 is empty or draining this cycle.
    if (bus.in_ready) begin
      s1_valid_d = bus.in_valid;
    end

    if (in_fire) begin
      s1_enc_d      = bus.encoding;
      s1_opcode_d   = bus.opcode;
      s1_funct3_d   = bus.funct3;
      s1_rd_d       = bus.rd;
      s1_rs1_d      = bus.rs1;
      s1_rs2_d      = bus.rs2;
      s1_imm_bits_d = imm_place(bus.encoding, bus.imm);
      s1_err_d      = ~imm_in_range(bus.encoding, bus.imm);
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2 word assembly
  // ---------------------------------------------------------------------------
  always_comb begin
    s1_word = s1_imm_bits_q;
    case (s1_enc_q)
      I_TYPE:         s1_word = s1_imm_bits_q
                              | {12'h0, s1_rs1_q, s1_funct3_q, s1_rd_q, s1_opcode_q};
      S_TYPE, B_TYPE: s1_word = s1_imm_bits_q
                              | {7'h0, s1_rs2_q, s1_rs1_q, s1_funct3_q, 5'h0, s1_opcode_q};
      U_TYPE:         s1_word = s1_imm_bits_q | {20'h0, s1_rd_q, s1_opcode_q};
      default:        s1_word = s1_imm_bits_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Stage 2 next-state and counter
  // ---------------------------------------------------------------------------
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_instr_d = s2_instr_q;
    s2_err_d   = s2_err_q;
    s2_drop_d  = s2_drop_q;

    if (s2_advance) begin
      s2_valid_d = s1_valid_q;
      s2_drop_d  = 1'b0;
      // Data only moves with a real request, so instruction keeps its last
      // value while the stage sits empty.
      if (s1_valid_q) begin
        s2_instr_d = s1_word;
        s2_err_d   = s1_err_q;
`ifdef INST_ENCODER_DROP_ERR_EN
        if (s1_err_q) begin
          s2_valid_d = 1'b0;
          s2_drop_d  = 1'b1;
        end
`endif
      end
    end

    count_d = count_q;
    if (out_fire) begin
      // Plain modular add gives the all-ones -> 0 wrap.
      count_d = count_q + COUNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the pre-edge value of its _d input.
  // NOTE: the datapath registers are reset as well as the valids because
  // instruction and range_error must read zero straight out of reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_valid_q    <= 1'b0;
      s1_enc_q      <= I_TYPE;
      s1_opcode_q   <= '0;
      s1_funct3_q   <= '0;
      s1_rd_q       <= '0;
      s1_rs1_q      <= '0;
      s1_rs2_q      <= '0;
      s1_imm_bits_q <= '0;
      s1_err_q      <= 1'b0;
      s2_valid_q    <= 1'b0;
      s2_instr_q    <= '0;
      s2_err_q      <= 1'b0;
      s2_drop_q     <= 1'b0;
      count_q       <= '0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      s1_enc_q      <= s1_enc_d;
      s1_opcode_q   <= s1_opcode_d;
      s1_funct3_q   <= s1_funct3_d;
      s1_rd_q       <= s1_rd_d;
      s1_rs1_q      <= s1_rs1_d;
      s1_rs2_q      <= s1_rs2_d;
      s1_imm_bits_q <= s1_imm_bits_d;
      s1_err_q      <= s1_err_d;
      s2_valid_q    <= s2_valid_d;
      s2_instr_q    <= s2_instr_d;
      s2_err_q      <= s2_err_d;
      s2_drop_q     <= s2_drop_d;
      count_q       <= count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.out_valid   = s2_valid_q;
  assign bus.instruction = s2_instr_q;
  // range_error is only meaningful with out_valid, except for the one-cycle
  // pulse of a dropped slot.
  assign bus.range_error = (s2_valid_q & s2_err_q) | s2_drop_q;
  assign enc_count       = count_q;

endmodule

// File: doc/inst_encoder.md
Name: inst_encoder

Overview:
- Inverse of the decode-side immediate generator: packs an immediate plus register and opcode fields into a 32-bit RV32I instruction word for I, U, S and B encodings.
- Intended for the debug/program-loader path, which assembles instructions to write into instruction memory.
- Two-stage valid/ready pipeline with immediate range checking and an emitted-instruction counter.

Parameters:
- COUNT_W, 16, width of the emitted-instruction counter enc_count.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  encoder can accept a request this cycle.
- encoding  in  encoding_type (common package)  I_TYPE / U_TYPE / S_TYPE / B_TYPE; any other value is raw pass-through.
- opcode  in  7  instruction[6:0].
- funct3  in  3  instruction[14:12]; ignored for U_TYPE.
- rd  in  5  destination register; used for I/U.
- rs1  in  5  source register 1; used for I/S/B.
- rs2  in  5  source register 2; used for S/B.
- imm  in  32  immediate, full 32-bit two's complement value (U: already shifted, bits 31:12 significant).
- out_valid  out  1  encoded word valid.
- out_ready  in  1  downstream accepts the word.
- instruction  out  32  encoded instruction word.
- range_error  out  1  imm not representable in the selected encoding; qualified by out_valid.
- enc_count  out  COUNT_W  number of output handshakes since reset.

Behaviour:
- Reset (reset_n low at a clk edge):
  - Both stage valids cleared; out_valid=0, instruction=0, range_error=0, enc_count=0.
  - in_ready=1 in the first cycle after reset is released.
  - Reset mid-operation discards all in-flight requests; no partial output.
- Handshake: transfer when valid && ready on the same edge. Once out_valid is asserted, instruction and range_error are held stable until out_ready.
- Stage 1 (registered): captures the request, computes the range check and the permuted immediate field bits.
- Stage 2 (registered): assembles the final word, drives out_valid, instruction and range_error.
- Latency: 2 cycles from the in handshake to out_valid with no backpressure. Throughput: 1 per cycle.
- Backpressure:
  - Stage 2 advances when empty or when out_ready=1.
  - Stage 1 advances when stage 2 advances.
  - in_ready = stage 1 empty or stage 1 advancing (combinational from out_ready).
  - No request is lost or duplicated; output order equals input order.
- Field packing (complementary to the decode-side immediate generator):
  - I_TYPE: {imm[11:0], rs1, funct3, rd, opcode}.
  - S_TYPE: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
  - B_TYPE: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
  - U_TYPE: {imm[31:12], rd, opcode}.
  - Other encodings: instruction = imm unchanged; range_error=0.
- Range rules (a violation sets range_error; the word is still emitted with truncated fields):
  - I/S: imm[31:11] all equal.
  - B: imm[31:12] all equal and imm[0]=0.
  - U: imm[11:0]=0.
- enc_count: increments by 1 on each out handshake (out_valid && out_ready), including errored words. Wraps from all-ones to 0.

Optional Feature:
- Macro: INST_ENCODER_DROP_ERR_EN.
- Defined:
  - A request failing the range check is consumed normally but never presented on the output; out_valid stays low for that slot.
  - enc_count does not increment for a dropped request.
  - range_error pulses high for exactly one cycle when the dropped request would have left stage 2.
- Undefined: behaviour exactly as in Behaviour above (errored words emitted with range_error=1).

Test Plan:
- I_TYPE, opcode=0010011, funct3=000, rd=1, rs1=0, imm=0xFFFFFFFF -> instruction=0xFFF00093, range_error=0, out_valid 2 cycles after accept, enc_count=1.
- S_TYPE, opcode=0100011, funct3=010, rs1=3, rs2=2, imm=8 -> 0x0021A423; B_TYPE, opcode=1100011, funct3=000, rs1=0, rs2=0, imm=0xFFFFFFFC -> 0xFE000EE3.
- U_TYPE, opcode=0110111, rd=5, imm=0x12345000 -> 0x123452B7. Same with imm=0x12345001 -> range_error=1, instruction=0x123452B7.
- I_TYPE, opcode=0010011, rd=1, rs1=0, imm=0x00000800 -> range_error=1, instruction=0x80000093. With INST_ENCODER_DROP_ERR_EN defined: no out_valid for this request, one-cycle range_error pulse, enc_count unchanged.
- Back-to-back stream of 4 requests with out_ready held low for 5 cycles:
  - in_ready drops after 2 accepts.
  - After out_ready rises, all 4 words emerge in order with no gaps; enc_count=4.
  - instruction is held stable while stalled.
- Reset and wrap:
  - Assert reset_n low while 2 requests are in flight -> next cycle out_valid=0, enc_count=0, and nothing is emitted afterwards.
  - With COUNT_W=2, 5 handshakes -> enc_count=1.
